// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pixel-domain types and colour constants
package video_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_BLACK = 24'h000000;
    localparam rgb_t RGB_WHITE = 24'hFFFFFF;
    localparam rgb_t RGB_RED   = 24'hFF0000;

endpackage

// File: rtl/video_if.sv
// rtl/video_if.sv - VGA-style pixel stream (RGB/HS/VS/BLANK, BLANK=1 active)
interface video_if;
    import video_pkg::*;

    logic CLK;
    rgb_t RGB;
    logic HS;
    logic VS;
    logic BLANK;

    modport master (output CLK, output RGB, output HS, output VS, output BLANK);
    modport slave  (input  CLK, input  RGB, input  HS, input  VS, input  BLANK);

endinterface

// File: rtl/video_pos_tracker.sv
// rtl/video_pos_tracker.sv - active-area x/y position and frame_start from sync/blank edges
module video_pos_tracker #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int XW    = $clog2(HDISP),
    parameter int YW    = $clog2(VDISP)
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic          blank_i,
    input  logic          vs_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          vs_fall_o,
    output logic          frame_start_o
);

    localparam logic [XW-1:0] X_MAX = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(VDISP - 1);

    logic          blank_prev_q;
    logic          vs_prev_q;
    logic [XW-1:0] x_cnt_q, x_cnt_d;
    logic [YW-1:0] y_cnt_q, y_cnt_d;
    logic          frame_start_q;
    logic          blank_fall;
    logic          vs_fall;

    // Previous-VS resets low so releasing reset during a sync pulse never fakes a frame start.
    assign blank_fall = blank_prev_q & ~blank_i;
    assign vs_fall    = vs_prev_q & ~vs_i;

    always_comb begin
        x_cnt_d = x_cnt_q;
        if (blank_fall)
            x_cnt_d = '0;
        else if (blank_i && x_cnt_q != X_MAX)
            x_cnt_d = x_cnt_q + 1'b1;
    end

    always_comb begin
        y_cnt_d = y_cnt_q;
        if (vs_fall)
            y_cnt_d = '0;
        else if (blank_fall && y_cnt_q != Y_MAX)
            y_cnt_d = y_cnt_q + 1'b1;
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            blank_prev_q  <= 1'b0;
            vs_prev_q     <= 1'b0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            blank_prev_q  <= blank_i;
            vs_prev_q     <= vs_i;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            frame_start_q <= vs_fall;
        end
    end

    assign x_o           = x_cnt_q;
    assign y_o           = y_cnt_q;
    assign vs_fall_o     = vs_fall;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/video_box_overlay.sv
// rtl/video_box_overlay.sv - frame-synchronous rectangular border overlay, 1-cycle latency
module video_box_overlay
    import video_pkg::*;
#(
    parameter int   HDISP     = 800,
    parameter int   VDISP     = 480,
    parameter int   BOX_W     = 64,
    parameter int   BOX_H     = 48,
    parameter int   BORDER    = 2,
    parameter rgb_t BOX_COLOR = RGB_RED
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    video_if.slave                     video_ifs,
    video_if.master                    video_ifm,
    input  logic                       box_en,
    input  logic [$clog2(HDISP)-1:0]   box_x,
    input  logic [$clog2(VDISP)-1:0]   box_y,
    output logic                       frame_start
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);

    localparam logic [XW:0] BW_X = (XW+1)'(BOX_W);
    localparam logic [XW:0] BD_X = (XW+1)'(BORDER);
    localparam logic [YW:0] BH_Y = (YW+1)'(BOX_H);
    localparam logic [YW:0] BD_Y = (YW+1)'(BORDER);

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          vs_fall;

    logic          sh_en_q, sh_en_d;
    logic [XW-1:0] sh_x_q,  sh_x_d;
    logic [YW-1:0] sh_y_q,  sh_y_d;

    rgb_t          rgb_q, rgb_d;
    logic          hs_q, vs_q, blank_q;

    video_pos_tracker #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .XW    (XW),
        .YW    (YW)
    ) u_pos (
        .pixel_clk     (pixel_clk),
        .pixel_rst     (pixel_rst),
        .blank_i       (video_ifs.BLANK),
        .vs_i          (video_ifs.VS),
        .x_o           (x_cnt),
        .y_o           (y_cnt),
        .vs_fall_o     (vs_fall),
        .frame_start_o (frame_start)
    );

    always_comb begin
        sh_en_d = sh_en_q;
        sh_x_d  = sh_x_q;
        sh_y_d  = sh_y_q;
        if (vs_fall) begin
            sh_en_d = box_en;
            sh_x_d  = box_x;
            sh_y_d  = box_y;
        end
    end

    // One spare bit so a box hanging off the right/bottom edge clips instead of wrapping.
    logic [XW:0] px, x_lo, x_hi, xi_lo, xi_hi;
    logic [YW:0] py, y_lo, y_hi, yi_lo, yi_hi;
    logic        outer_hit, inner_hit, border_hit;

    assign px    = {1'b0, x_cnt};
    assign x_lo  = {1'b0, sh_x_q};
    assign x_hi  = x_lo + BW_X;
    assign xi_lo = x_lo + BD_X;
    assign xi_hi = x_hi - BD_X;

    assign py    = {1'b0, y_cnt};
    assign y_lo  = {1'b0, sh_y_q};
    assign y_hi  = y_lo + BH_Y;
    assign yi_lo = y_lo + BD_Y;
    assign yi_hi = y_hi - BD_Y;

    assign outer_hit  = (px >= x_lo)  && (px < x_hi)  && (py >= y_lo)  && (py < y_hi);
    assign inner_hit  = (px >= xi_lo) && (px < xi_hi) && (py >= yi_lo) && (py < yi_hi);
    assign border_hit = outer_hit && !inner_hit && video_ifs.BLANK && sh_en_q;

    assign rgb_d = border_hit ? BOX_COLOR : video_ifs.RGB;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            sh_en_q <= 1'b0;
            sh_x_q  <= '0;
            sh_y_q  <= '0;
            rgb_q   <= RGB_BLACK;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            sh_en_q <= sh_en_d;
            sh_x_q  <= sh_x_d;
            sh_y_q  <= sh_y_d;
            rgb_q   <= rgb_d;
            hs_q    <= video_ifs.HS;
            vs_q    <= video_ifs.VS;
            blank_q <= video_ifs.BLANK;
        end
    end

    assign video_ifm.CLK   = pixel_clk;
    assign video_ifm.RGB   = rgb_q;
    assign video_ifm.HS    = hs_q;
    assign video_ifm.VS    = vs_q;
    assign video_ifm.BLANK = blank_q;

endmodule

// File: tb/tb_video_box_overlay.sv
// tb/tb_video_box_overlay.sv - randomized frames checked against a pixel-coordinate box model
module tb_video_box_overlay;
    import video_pkg::*;

    localparam int HD = 80;
    localparam int VD = 48;
    localparam int BW = 24;
    localparam int BH = 16;
    localparam int BD = 2;
    localparam int XW = $clog2(HD);
    localparam int YW = $clog2(VD);
    localparam logic [23:0] RED = 24'hFF0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          box_en;
    logic [XW-1:0] box_x;
    logic [YW-1:0] box_y;
    logic          frame_start;

    video_if vin();
    video_if vout();

    assign vin.CLK = clk;
    always #5 clk = ~clk;

    video_box_overlay #(
        .HDISP     (HD),
        .VDISP     (VD),
        .BOX_W     (BW),
        .BOX_H     (BH),
        .BORDER    (BD),
        .BOX_COLOR (RED)
    ) dut (
        .pixel_clk   (clk),
        .pixel_rst   (rst),
        .video_ifs   (vin),
        .video_ifm   (vout),
        .box_en      (box_en),
        .box_x       (box_x),
        .box_y       (box_y),
        .frame_start (frame_start)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int fs_seen;

    bit m_prev_vs;
    bit fr_en;
    int fr_x, fr_y;

    logic [23:0] in_img  [HD][VD];
    logic [23:0] out_img [HD][VD];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit on_border(input int x, input int y);
        int  cx, cy;
        bit  outer, inner;
        cx = (x > HD - 1) ? HD - 1 : x;
        cy = (y > VD - 1) ? VD - 1 : y;
        outer = cx >= fr_x && cx < fr_x + BW && cy >= fr_y && cy < fr_y + BH;
        inner = cx >= fr_x + BD && cx < fr_x + BW - BD && cy >= fr_y + BD && cy < fr_y + BH - BD;
        return outer && !inner;
    endfunction

    task automatic step(input logic [23:0] rgb, input bit hs, input bit vs, input bit blank,
                        input int px, input int py);
        logic [23:0] e_rgb;
        bit          e_hs, e_vs, e_bl, e_fs;
        vin.RGB   = rgb;
        vin.HS    = hs;
        vin.VS    = vs;
        vin.BLANK = blank;
        if (rst) begin
            e_rgb = 24'h0; e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fs = 1'b0;
            m_prev_vs = 1'b0; fr_en = 1'b0; fr_x = 0; fr_y = 0;
        end else begin
            e_rgb = (blank && fr_en && on_border(px, py)) ? RED : rgb;
            e_hs = hs; e_vs = vs; e_bl = blank;
            e_fs = m_prev_vs && !vs;
            if (e_fs) begin
                fr_en = box_en; fr_x = int'(box_x); fr_y = int'(box_y);
            end
            m_prev_vs = vs;
        end
        @(posedge clk);
        #1;
        chk("rgb",   32'(vout.RGB),   32'(e_rgb));
        chk("hs",    32'(vout.HS),    32'(e_hs));
        chk("vs",    32'(vout.VS),    32'(e_vs));
        chk("blank", 32'(vout.BLANK), 32'(e_bl));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        if (frame_start) fs_seen++;
        if (!rst && blank && px < HD && py < VD) begin
            in_img[px][py]  = rgb;
            out_img[px][py] = vout.RGB;
        end
    endtask

    task automatic frame(input int act_l, input int act_p, input int chg_line,
                         input bit n_en, input int n_x, input int n_y, input int rst_line);
        int rcnt;
        bit act, bl;
        int py;
        rcnt = 0;
        fs_seen = 0;
        for (int l = 0; l < act_l + 4; l++) begin
            for (int c = 0; c < act_p + 12; c++) begin
                act = (l >= 3) && (l < 3 + act_l);
                bl  = act && (c < act_p);
                py  = l - 3;
                if (act && py == chg_line && c == act_p / 2) begin
                    box_en = n_en;
                    box_x  = XW'(n_x);
                    box_y  = YW'(n_y);
                end
                if (act && py == rst_line && c == act_p / 2) rcnt = 3;
                rst = (rcnt > 0);
                if (rcnt > 0) rcnt--;
                step(24'($urandom), (c < act_p + 2) || (c >= act_p + 8), l >= 2, bl, c, py);
            end
        end
        chk("frame_start_per_frame", 32'(fs_seen), 32'd1);
    endtask

    task automatic px_chk(input string tag, input int x, input int y, input bit red);
        chk(tag, 32'(out_img[x][y]), red ? 32'(RED) : 32'(in_img[x][y]));
    endtask

    initial begin
        rst = 1'b1; box_en = 1'b0; box_x = '0; box_y = '0;
        vin.RGB = '0; vin.HS = 1'b1; vin.VS = 1'b1; vin.BLANK = 1'b0;
        m_prev_vs = 1'b0; fr_en = 1'b0; fr_x = 0; fr_y = 0; fs_seen = 0;

        for (int i = 0; i < 4; i++) step(24'($urandom), 1'b0, 1'b0, 1'b1, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(24'($urandom), 1'b1, 1'b1, 1'b0, 0, 0);

        // Disabled frame; enabling mid-frame must not show until the next frame.
        frame(VD, HD, 5, 1'b1, 0, 0, -1);

        frame(VD, HD, 20, 1'b1, 20, 10, -1);
        px_chk("box00_0_0",   0,  0, 1'b1);
        px_chk("box00_1_1",   1,  1, 1'b1);
        px_chk("box00_23_15", 23, 15, 1'b1);
        px_chk("box00_0_15",  0, 15, 1'b1);
        px_chk("box00_2_2",   2,  2, 1'b0);
        px_chk("box00_21_13", 21, 13, 1'b0);
        px_chk("box00_24_0",  24,  0, 1'b0);
        px_chk("box00_0_16",  0, 16, 1'b0);

        frame(VD, HD, 30, 1'b1, 70, 0, -1);
        px_chk("mv_19_15", 19, 15, 1'b0);
        px_chk("mv_20_15", 20, 15, 1'b1);
        px_chk("mv_21_15", 21, 15, 1'b1);
        px_chk("mv_22_15", 22, 15, 1'b0);
        px_chk("mv_43_15", 43, 15, 1'b1);
        px_chk("mv_44_15", 44, 15, 1'b0);
        px_chk("mv_30_10", 30, 10, 1'b1);
        px_chk("mv_30_12", 30, 12, 1'b0);
        px_chk("mv_30_25", 30, 25, 1'b1);
        px_chk("mv_30_26", 30, 26, 1'b0);

        frame(VD, HD, 10, 1'b1, 10, 40, -1);
        px_chk("clip_70_5", 70, 5, 1'b1);
        px_chk("clip_71_5", 71, 5, 1'b1);
        px_chk("clip_72_5", 72, 5, 1'b0);
        px_chk("clip_79_5", 79, 5, 1'b0);
        px_chk("clip_79_0", 79, 0, 1'b1);
        px_chk("clip_79_1", 79, 1, 1'b1);
        px_chk("clip_79_2", 79, 2, 1'b0);
        px_chk("clip_0_1",  0,  1, 1'b0);

        frame(VD, HD, 10, 1'b1, int'($urandom_range(HD - 1)), int'($urandom_range(VD - 1)), -1);
        px_chk("bclip_20_40", 20, 40, 1'b1);
        px_chk("bclip_20_41", 20, 41, 1'b1);
        px_chk("bclip_20_42", 20, 42, 1'b0);
        px_chk("bclip_20_47", 20, 47, 1'b0);

        for (int f = 0; f < 3; f++)
            frame(VD, HD, int'($urandom_range(VD - 1)), ($urandom_range(3) != 0),
                  int'($urandom_range(HD - 1)), int'($urandom_range(VD - 1)), -1);

        // Overlong lines and extra lines exercise counter saturation.
        frame(VD + 4, HD + 4, 10, 1'b1, HD - BW / 2, VD - BH / 2, -1);

        frame(VD, HD, 10, 1'b1, 30, 20, 20);
        px_chk("rst_no_box_30_30", 30, 30, 1'b0);

        frame(VD, HD, -1, 1'b0, 0, 0, -1);
        px_chk("recov_30_25", 30, 25, 1'b1);
        px_chk("recov_32_25", 32, 25, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
